hub75_scan_engine: RTL
======================

Name: hub75_scan_engine

Overview:
Parametrised HUB75 scan engine driving CHANNELS parallel RGB data lanes from a frame buffer using binary-coded modulation (BCM) with BITS bitplanes. Bitplane shifting overlaps the display period of the previous bitplane. Row selection goes through a shift-register row driver (row_clk/row_data). Sits between the frame-buffer read port and the panel pins in hub75_top, and generalises the fixed four-panel output stage.

Parameters:
CHANNELS, 4, parallel RGB lanes (r/g/b triple per lane)
COLS, 128, pixels shifted per row per lane
ROWS, 32, scan rows (row-select chain length)
BITS, 8, colour depth per component (bitplanes)
BASE_ON, 16, blank-low clk cycles for bitplane 0; must be >= 1
AW, $clog2(ROWS*COLS), frame-buffer address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run scanning; sampled only in IDLE and at frame end
rd_addr  out  AW  frame-buffer read address = row*COLS + col
rd_data  in  CHANNELS*3*BITS  pixel word, valid 1 cycle after rd_addr; bit index c*3*BITS + k*BITS + b (k: 0=R, 1=G, 2=B)
rgb  out  CHANNELS*3  panel data; bit c*3+k = lane c colour k
clk_out  out  1  panel shift clock
lat  out  1  panel latch
blank  out  1  panel output-enable, active high = dark
row_clk  out  1  row-select shift clock
row_data  out  1  row-select data
frame_start  out  1  one-cycle pulse when row 0 plane 0 shift begins

Behaviour:
- Reset (async, any state): state IDLE; rgb=0, clk_out=0, lat=0, blank=1, row_clk=0, row_data=0, frame_start=0, rd_addr=0, row=0, plane=0, display counter=0. Reset mid-shift or mid-latch aborts immediately; no partial latch.
- States: IDLE, SHIFT, WAIT, LATCH.
- IDLE: blank=1. On enable=1 -> SHIFT with row=0, plane=0; frame_start=1 on the first SHIFT cycle.
- SHIFT, 2*COLS+1 cycles, cycle index t from 0:
  - Column k: rd_addr=row*COLS+k during cycle 2k.
  - rgb = bit `plane` of each lane's colours from rd_data, registered at the end of cycle 2k+1 and held for cycles 2k+2..2k+3.
  - clk_out=1 during cycle 2k+3, else 0, so the rising edge is centred on stable data.
  - After the last column -> WAIT.
- WAIT: hold rgb. Decrement the display counter each cycle while nonzero. blank stays low while counter>0; blank=1 when it reaches 0. Go to LATCH when counter==0, which is immediate if already 0 (first plane after IDLE, or shift longer than display time).
- LATCH, 3 cycles, blank=1 throughout:
  - L0: if plane==0 (new row being latched), row_clk=1 and row_data=(row==0).
  - L1: lat=1.
  - L2: lat=0.
  - Then load counter = BASE_ON<<plane and deassert blank on the next cycle. Counter width $clog2(BASE_ON<<(BITS-1))+1, with no overflow.
- After LATCH, advance: plane+1; at plane BITS-1, wrap to 0 and row+1; at row ROWS-1, wrap to 0 (frame end).
- At frame end with enable=1: -> SHIFT, frame_start pulse.
- At frame end with enable=0: -> WAIT for the counter to expire, then IDLE with blank=1.
- enable deassert mid-frame: the frame completes, then the engine stops.
- Per row, the panel shows plane p for exactly BASE_ON<<p cycles of blank=0, whenever that exceeds the shift time.
- Row-select chain receives exactly ROWS row_clk pulses per frame; row_data=1 only on the pulse latching row 0.
- rd_addr holds its last value outside SHIFT.

Test Plan:
1. Reset: assert rst_n=0 mid-SHIFT -> all outputs take their reset values in the same cycle without a clk edge; blank=1, lat=0.
2. Shift timing (CHANNELS=2, COLS=4, ROWS=4, BITS=2, BASE_ON=32), rd_data=col-dependent pattern -> rd_addr 0,1,2,3 at t=0,2,4,6; 4 clk_out pulses at t=3,5,7,9; rgb at each rising edge equals plane-0 bits of that column.
3. BCM timing (same params) -> blank low for exactly 32 cycles (plane 0) then 64 (plane 1) per row; lat high 1 cycle inside each 3-cycle blank window.
4. Row select -> 4 row_clk pulses per frame, each only on plane-0 latches; row_data=1 only on the first; frame_start once per 8 latches.
5. Short display (BASE_ON=1) -> WAIT takes 0 cycles; successive lat pulses spaced 2*COLS+1+3 = 12 cycles.
6. enable=0 at row 1 -> rows 2, 3 still latched; then blank=1 and IDLE with no further rd_addr change; re-enable -> frame_start and rd_addr=0.

Source files
------------

// File: rtl/hub75_scan_engine.sv
// HUB75 scan engine: binary-coded modulation over BITS bitplanes, shifting the
// next bitplane while the previous one is on display, plus row-select chain drive.
//
// state | meaning
// IDLE  | panel dark, waiting for enable
// SHIFT | clocking one bitplane of one row into the column drivers
// WAIT  | shift finished, previous bitplane still on display
// LATCH | L0 row_clk, L1 lat, L2 load display time for the latched plane
module hub75_scan_engine #(
  parameter int CHANNELS = 4,
  parameter int COLS     = 128,
  parameter int ROWS     = 32,
  parameter int BITS     = 8,
  parameter int BASE_ON  = 16,
  parameter int AW       = $clog2(ROWS*COLS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic [AW-1:0]              rd_addr,
  input  logic [CHANNELS*3*BITS-1:0] rd_data,
  output logic [CHANNELS*3-1:0]      rgb,
  output logic                       clk_out,
  output logic                       lat,
  output logic                       blank,
  output logic                       row_clk,
  output logic                       row_data,
  output logic                       frame_start
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW    = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TW    = $clog2(2*COLS+1);
  localparam int DW    = $clog2(BASE_ON << (BITS-1)) + 1;
  localparam int LANES = CHANNELS*3;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_LATCH} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   t_q, t_inc;
  logic [1:0]      l_q;
  logic [RW-1:0]   row, row_n;
  logic [PW-1:0]   plane, plane_n;
  logic [DW-1:0]   disp_cnt;
  logic            stop_q;
  logic [AW-1:0]   row_base;
  logic [LANES-1:0] rgb_sel;
  logic            shift_done, latch_done, last_plane, last_row, frame_end, cnt_low, halt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BITS-1:0] comp;
    assign comp       = rd_data[i*BITS +: BITS];
    assign rgb_sel[i] = comp[plane];
  end

  assign t_inc      = t_q + TW'(1);
  assign row_base   = AW'(row) * AW'(COLS);
  assign shift_done = (state == S_SHIFT) && (t_q == TW'(2*COLS));
  assign latch_done = (state == S_LATCH) && (l_q == 2'd2);
  assign last_plane = (plane == PW'(BITS-1));
  assign last_row   = (row == RW'(ROWS-1));
  assign frame_end  = last_plane && last_row;
  assign halt       = frame_end && !enable;
  // counter reaches zero on the coming edge, so the next state sees it expired
  assign cnt_low    = (disp_cnt <= DW'(1));

  always_comb begin
    plane_n = last_plane ? '0 : plane + PW'(1);
    row_n   = row;
    if (last_plane) row_n = last_row ? '0 : row + RW'(1);
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (enable) state_d = S_SHIFT;
      S_SHIFT: if (shift_done) state_d = cnt_low ? S_LATCH : S_WAIT;
      S_WAIT:  if (cnt_low) state_d = stop_q ? S_IDLE : S_LATCH;
      S_LATCH: if (latch_done) state_d = halt ? S_WAIT : S_SHIFT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      t_q      <= '0;
      l_q      <= '0;
      row      <= '0;
      plane    <= '0;
      disp_cnt <= '0;
      stop_q   <= 1'b0;
      rd_addr  <= '0;
      rgb      <= '0;
      clk_out  <= 1'b0;
    end else begin
      state   <= state_d;
      clk_out <= 1'b0;
      if (disp_cnt != '0) disp_cnt <= disp_cnt - DW'(1);
      if (state != S_SHIFT) t_q <= '0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            row     <= '0;
            plane   <= '0;
            rd_addr <= '0;
          end
        end
        S_SHIFT: begin
          t_q <= t_inc;
          // odd cycles capture data and present the next address; even cycles clock it out
          if (t_q[0]) begin
            rgb <= rgb_sel;
            if (t_q < TW'(2*COLS-1)) rd_addr <= row_base + AW'(t_inc[TW-1:1]);
          end else if (t_q != '0) begin
            clk_out <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_low && stop_q) stop_q <= 1'b0;
        end
        S_LATCH: begin
          l_q <= l_q + 2'd1;
          if (latch_done) begin
            l_q      <= '0;
            disp_cnt <= DW'(BASE_ON) << plane;
            row      <= row_n;
            plane    <= plane_n;
            stop_q   <= halt;
            if (!halt) rd_addr <= AW'(row_n) * AW'(COLS);
          end
        end
        default: ;
      endcase
    end
  end

  assign lat         = (state == S_LATCH) && (l_q == 2'd1);
  assign row_clk     = (state == S_LATCH) && (l_q == 2'd0) && (plane == '0);
  assign row_data    = row_clk && (row == '0);
  assign blank       = (state == S_IDLE) || (state == S_LATCH) || (disp_cnt == '0);
  assign frame_start = (state == S_SHIFT) && (t_q == '0) && (row == '0) && (plane == '0);

endmodule
